shared_ram_arbiter: RTL and testbench
=====================================

Name: shared_ram_arbiter

Overview:
- Arbitrates the single-port 2K x 8 shared RAM between the M68K and the sound Z80.
- M68K side: window 0x180000-0x180fff, low byte lane only, word-addressed by cpu_a[11:1].
- Z80 side: selected by an external Z80 memory decode.
- Sequences every RAM access, generates M68K DTACK and Z80 WAIT, and returns read data to each CPU.

Parameters:
- ADDR_W, 11, shared RAM address width (2048 bytes).
- DATA_W, 8, shared RAM data width.
- RAM_LATENCY, 1, clocks from address to ram_q valid; legal values are 1 and 2.

Ports:
- clk_sys  in  1  system clock; both CPUs run on clock enables in this domain.
- reset_n  in  1  asynchronous active-low reset.
- shared_ram_cs  in  1  M68K select (includes !cpu_as_n).
- cpu_a  in  ADDR_W  M68K address bits [11:1].
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_lds_n  in  1  M68K lower data strobe.
- cpu_dout  in  DATA_W  M68K write data (low byte).
- m68k_ram_dout  out  DATA_W  registered read data to M68K.
- m68k_dtack_n  out  1  M68K acknowledge.
- z80_ram_cs  in  1  Z80 select (MREQ_n low and in range).
- z80_addr  in  ADDR_W  Z80 address [10:0].
- z80_rd_n  in  1  Z80 read strobe.
- z80_wr_n  in  1  Z80 write strobe.
- z80_dout  in  DATA_W  Z80 write data.
- z80_ram_dout  out  DATA_W  registered read data to Z80.
- z80_wait_n  out  1  Z80 WAIT, active low.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable, one clock pulse.
- ram_q  in  DATA_W  RAM read data.

Behaviour:
- Reset values:
  - state IDLE; m68k_dtack_n = 1; z80_wait_n = 1.
  - ram_we = 0; ram_addr = 0; ram_din = 0; both dout registers = 0.
  - served_m = served_z = 0; last_grant = Z80, so the M68K wins the first tie.
- Requests:
  - req_m = shared_ram_cs & !served_m & !busy_m.
  - req_z = z80_ram_cs & (!z80_rd_n | !z80_wr_n) & !served_z & !busy_z.
- FSM states: IDLE, ACCESS, DATA.
  - IDLE: with one request, grant that side. With both, grant the side that is not last_grant (round-robin).
    - On grant, latch address, rw and write data into ram_addr/ram_din.
    - ram_we = write & (M68K: !cpu_lds_n), for one clock.
    - Set busy for the granted side, update last_grant, go to ACCESS.
  - ACCESS: ram_we = 0.
    - Write: complete now and go to IDLE.
    - Read: count RAM_LATENCY-1 extra clocks, then go to DATA.
  - DATA: capture ram_q into the granted side's dout register, complete, go to IDLE.
- Complete:
  - Clear busy.
  - If that side's cs is still high, set served; this drops m68k_dtack_n or releases the Z80 wait on the same edge.
  - If cs has already dropped, set nothing (aborted access; a latched write is still performed).
- Handshake release:
  - served_m clears on the first clock with shared_ram_cs low; m68k_dtack_n = 1 on the same edge.
  - served_z clears likewise when z80_ram_cs goes low.
- z80_wait_n is combinational: 0 when z80_ram_cs & !served_z & reset_n; otherwise 1. WAIT asserts in the same cycle as the select.
- Latency, counted from the edge that samples the request in IDLE:
  - Write: acknowledged 2 edges later.
  - Read: acknowledged 2+RAM_LATENCY edges later.
  - Worst-case added stall is one full access of the other side.
- M68K write with cpu_lds_n high: no RAM write, DTACK still given. M68K reads always return the low byte.
- No back-to-back same-side access without the cs dropping first.
- Asynchronous reset mid-access: the access is abandoned, ram_we drops immediately, and all outputs take their reset values.

Optional Feature:
- Macro SHRAM_CONTENTION_CNT_EN.
- Defined:
  - Adds output contention_cnt [15:0].
  - Increments (saturating at 0xffff) on each clock where either side has a pending request while the FSM is not in IDLE.
  - Clears on reset.
- Undefined: port and counter absent; the rest of the behaviour is identical.

Decomposition:
- Package shared_ram_pkg holds:
  - ADDR_W and DATA_W defaults.
  - State enum {IDLE, ACCESS, DATA}.
  - Grant encoding {GNT_M68K = 0, GNT_Z80 = 1}.
- One sub-module, shram_req_tracker, is instantiated per side. It holds the served/busy flags, request generation and cs-drop release.
- The FSM and datapath stay in shared_ram_arbiter.

Test Plan:
- M68K write 0x5a to cpu_a = 0x123 (byte 0x180246), lds_n = 0, RAM_LATENCY = 1 -> one ram_we pulse with ram_addr 0x123 and ram_din 0x5a; dtack_n low 2 edges after the request; dtack_n high one edge after cs drops.
- Z80 read of 0x123 after that write -> z80_wait_n low the same cycle cs rises; z80_ram_dout = 0x5a; wait_n high 3 edges after the request.
- Simultaneous M68K read and Z80 write, both on the same edge after reset -> M68K granted first; Z80 ram_we follows after the M68K read completes; next tie grants the Z80.
- M68K write with lds_n = 1 -> ram_we never asserted, dtack_n still low 2 edges after the request.
- M68K drops cs during ACCESS on a write -> write still performed, served_m stays 0, dtack_n stays 1; a Z80 request pending at that time is granted on the following IDLE.
- reset_n low during DATA -> ram_we = 0, dtack_n = 1, wait_n = 1 immediately; after release, a fresh M68K read completes normally (with SHRAM_CONTENTION_CNT_EN, counter reads 0).

Source files
------------

// File: rtl/shared_ram_pkg.sv
// Shared definitions for the M68K / Z80 shared-RAM arbiter.
// Optional contention counter lives in the top, guarded by SHRAM_CONTENTION_CNT_EN.
package shared_ram_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 11;
    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DATA
    } state_t;

    typedef enum logic {
        GNT_M68K = 1'b0,
        GNT_Z80  = 1'b1
    } grant_t;

endpackage

// File: rtl/shram_req_tracker.sv
// Per-CPU request bookkeeping: busy while granted, served until the select drops.
module shram_req_tracker (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic cs,
    input  logic strobe,
    input  logic grant,
    input  logic complete,
    output logic req,
    output logic served
);

    logic busy_q;
    logic served_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= 1'b0;
            served_q <= 1'b0;
        end else begin
            if (grant) begin
                busy_q <= 1'b1;
            end else if (complete) begin
                busy_q <= 1'b0;
            end
            // An access whose select already dropped completes silently (abort).
            if (!cs) begin
                served_q <= 1'b0;
            end else if (complete) begin
                served_q <= 1'b1;
            end
        end
    end

    assign req    = cs & strobe & ~served_q & ~busy_q;
    assign served = served_q;

endmodule

// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter for the 2K x 8 shared RAM between the M68K and the sound Z80.
// Define SHRAM_CONTENTION_CNT_EN to add the saturating contention_cnt output.
module shared_ram_arbiter
    import shared_ram_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              shared_ram_cs,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic              cpu_rw,
    input  logic              cpu_lds_n,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] m68k_ram_dout,
    output logic              m68k_dtack_n,
    input  logic              z80_ram_cs,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic              z80_rd_n,
    input  logic              z80_wr_n,
    input  logic [DATA_W-1:0] z80_dout,
    output logic [DATA_W-1:0] z80_ram_dout,
    output logic              z80_wait_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
`ifdef SHRAM_CONTENTION_CNT_EN
    output logic [15:0]       contention_cnt,
`endif
    input  logic [DATA_W-1:0] ram_q
);

    state_t     state_q;
    grant_t     gnt_q;
    grant_t     last_q;
    logic       rd_q;
    logic [1:0] lat_cnt_q;

    logic req_m, req_z, served_m, served_z;
    logic pick_z, grant_m, grant_z, done, complete_m, complete_z;

    // Z80 wins only if the M68K is idle or the M68K held the last grant.
    assign pick_z     = req_z & (~req_m | (last_q == GNT_M68K));
    assign grant_m    = (state_q == IDLE) & req_m & ~pick_z;
    assign grant_z    = (state_q == IDLE) & pick_z;
    assign done       = ((state_q == ACCESS) & ~rd_q) | (state_q == DATA);
    assign complete_m = done & (gnt_q == GNT_M68K);
    assign complete_z = done & (gnt_q == GNT_Z80);

    shram_req_tracker u_track_m (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .cs       (shared_ram_cs),
        .strobe   (1'b1),
        .grant    (grant_m),
        .complete (complete_m),
        .req      (req_m),
        .served   (served_m)
    );

    shram_req_tracker u_track_z (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .cs       (z80_ram_cs),
        .strobe   (~z80_rd_n | ~z80_wr_n),
        .grant    (grant_z),
        .complete (complete_z),
        .req      (req_z),
        .served   (served_z)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            gnt_q         <= GNT_M68K;
            last_q        <= GNT_Z80;
            rd_q          <= 1'b0;
            lat_cnt_q     <= 2'd0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_din       <= '0;
            m68k_ram_dout <= '0;
            z80_ram_dout  <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state_q)
                IDLE: begin
                    lat_cnt_q <= 2'd0;
                    if (grant_m) begin
                        gnt_q    <= GNT_M68K;
                        last_q   <= GNT_M68K;
                        rd_q     <= cpu_rw;
                        ram_addr <= cpu_a;
                        ram_din  <= cpu_dout;
                        ram_we   <= ~cpu_rw & ~cpu_lds_n;
                        state_q  <= ACCESS;
                    end else if (grant_z) begin
                        gnt_q    <= GNT_Z80;
                        last_q   <= GNT_Z80;
                        rd_q     <= z80_wr_n;
                        ram_addr <= z80_addr;
                        ram_din  <= z80_dout;
                        ram_we   <= ~z80_wr_n;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!rd_q) begin
                        state_q <= IDLE;
                    end else if (lat_cnt_q == 2'(RAM_LATENCY - 1)) begin
                        state_q <= DATA;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 2'd1;
                    end
                end
                DATA: begin
                    if (gnt_q == GNT_M68K) begin
                        m68k_ram_dout <= ram_q;
                    end else begin
                        z80_ram_dout <= ram_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m68k_dtack_n = ~served_m;
    assign z80_wait_n   = ~(z80_ram_cs & ~served_z & reset_n);

`ifdef SHRAM_CONTENTION_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 16'd0;
        end else if ((req_m | req_z) && (state_q != IDLE) && (cnt_q != 16'hffff)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign contention_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Self-checking bench for shared_ram_arbiter: directed scenarios plus randomized traffic
// checked against a shadow-memory / round-robin model. Honours SHRAM_CONTENTION_CNT_EN.
module tb_shared_ram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        shared_ram_cs = 1'b0;
    logic [10:0] cpu_a = '0;
    logic        cpu_rw = 1'b1;
    logic        cpu_lds_n = 1'b1;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  m68k_ram_dout;
    logic        m68k_dtack_n;
    logic        z80_ram_cs = 1'b0;
    logic [10:0] z80_addr = '0;
    logic        z80_rd_n = 1'b1;
    logic        z80_wr_n = 1'b1;
    logic [7:0]  z80_dout = '0;
    logic [7:0]  z80_ram_dout;
    logic        z80_wait_n;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_q = '0;
`ifdef SHRAM_CONTENTION_CNT_EN
    logic [15:0] contention_cnt;
`endif

    logic [7:0]  mem    [2048];
    logic [7:0]  shadow [2048];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          we_cnt  = 0;
    logic [10:0] we_addr = '0;
    logic [7:0]  we_din  = '0;
    logic        last_z  = 1'b1;

    always #5 clk_sys = ~clk_sys;

    shared_ram_arbiter dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .shared_ram_cs  (shared_ram_cs),
        .cpu_a          (cpu_a),
        .cpu_rw         (cpu_rw),
        .cpu_lds_n      (cpu_lds_n),
        .cpu_dout       (cpu_dout),
        .m68k_ram_dout  (m68k_ram_dout),
        .m68k_dtack_n   (m68k_dtack_n),
        .z80_ram_cs     (z80_ram_cs),
        .z80_addr       (z80_addr),
        .z80_rd_n       (z80_rd_n),
        .z80_wr_n       (z80_wr_n),
        .z80_dout       (z80_dout),
        .z80_ram_dout   (z80_ram_dout),
        .z80_wait_n     (z80_wait_n),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_we         (ram_we),
`ifdef SHRAM_CONTENTION_CNT_EN
        .contention_cnt (contention_cnt),
`endif
        .ram_q          (ram_q)
    );

    // Synchronous RAM with one clock of read latency.
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    always @(posedge clk_sys) begin
        if (ram_we) begin
            we_cnt++;
            we_addr = ram_addr;
            we_din  = ram_din;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    function automatic void model_acc(input logic wr, input logic [10:0] a, input logic [7:0] d,
                                      output logic [7:0] q);
        q = shadow[a];
        if (wr) shadow[a] = d;
    endfunction

    task automatic m68k_op(input logic rd, input logic [10:0] a, input logic [7:0] d,
                           input logic lds_n, input int exp_edges, input logic [7:0] exp_q,
                           input string tag);
        int   n = 0;
        logic ack = 1'b0;
        shared_ram_cs = 1'b1; cpu_a = a; cpu_rw = rd; cpu_lds_n = lds_n; cpu_dout = d;
        while (!ack && n < 40) begin
            @(posedge clk_sys); #1;
            n++;
            ack = !m68k_dtack_n;
        end
        check_val({tag, "_dtack_edges"}, n, exp_edges);
        if (rd) check_val({tag, "_m68k_dout"}, m68k_ram_dout, exp_q);
        shared_ram_cs = 1'b0; cpu_rw = 1'b1; cpu_lds_n = 1'b1;
        tick();
        check_val({tag, "_dtack_release"}, m68k_dtack_n, 1);
    endtask

    task automatic z80_op(input logic rd, input logic [10:0] a, input logic [7:0] d,
                          input int exp_edges, input logic [7:0] exp_q, input string tag);
        int   n = 0;
        logic rel = 1'b0;
        z80_ram_cs = 1'b1; z80_addr = a; z80_rd_n = !rd; z80_wr_n = rd; z80_dout = d;
        #1;
        check_val({tag, "_wait_assert"}, z80_wait_n, 0);
        while (!rel && n < 40) begin
            @(posedge clk_sys); #1;
            n++;
            rel = z80_wait_n;
        end
        check_val({tag, "_wait_edges"}, n, exp_edges);
        if (rd) check_val({tag, "_z80_dout"}, z80_ram_dout, exp_q);
        z80_ram_cs = 1'b0; z80_rd_n = 1'b1; z80_wr_n = 1'b1;
        tick();
    endtask

    // kind: 0 = M68K only, 1 = Z80 only, 2 = both on the same edge.
    task automatic run_pair(input int kind, input logic m_rd, input logic [10:0] m_a,
                            input logic [7:0] m_d, input logic m_lds, input logic z_rd,
                            input logic [10:0] z_a, input logic [7:0] z_d, input string tag);
        int         m_len = m_rd ? 3 : 2;
        int         z_len = z_rd ? 3 : 2;
        int         m_edges = 0, z_edges = 0, we_exp = 0, we0;
        logic       m_wr = !m_rd && !m_lds;
        logic       z_wr = !z_rd;
        logic [7:0] m_q = '0, z_q = '0;
        we0 = we_cnt;
        if (kind != 1) we_exp += int'(m_wr);
        if (kind != 0) we_exp += int'(z_wr);
        if (kind == 0) begin
            model_acc(m_wr, m_a, m_d, m_q); m_edges = m_len; last_z = 1'b0;
        end else if (kind == 1) begin
            model_acc(z_wr, z_a, z_d, z_q); z_edges = z_len; last_z = 1'b1;
        end else if (last_z) begin
            model_acc(m_wr, m_a, m_d, m_q); model_acc(z_wr, z_a, z_d, z_q);
            m_edges = m_len; z_edges = m_len + z_len; last_z = 1'b1;
        end else begin
            model_acc(z_wr, z_a, z_d, z_q); model_acc(m_wr, m_a, m_d, m_q);
            z_edges = z_len; m_edges = z_len + m_len; last_z = 1'b0;
        end
        if (kind == 0) begin
            m68k_op(m_rd, m_a, m_d, m_lds, m_edges, m_q, {tag, "_m"});
        end else if (kind == 1) begin
            z80_op(z_rd, z_a, z_d, z_edges, z_q, {tag, "_z"});
        end else begin
            fork
                m68k_op(m_rd, m_a, m_d, m_lds, m_edges, m_q, {tag, "_m"});
                z80_op(z_rd, z_a, z_d, z_edges, z_q, {tag, "_z"});
            join
        end
        check_val({tag, "_we_count"}, we_cnt - we0, we_exp);
        if (we_exp == 1 && kind != 2) begin
            check_val({tag, "_we_addr"}, we_addr, (kind == 0) ? m_a : z_a);
            check_val({tag, "_we_din"}, we_din, (kind == 0) ? m_d : z_d);
        end
    endtask

    initial begin
        int   n;
        logic dt_low;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 8'h00;
            shadow[i] = 8'h00;
        end

        // Reset values, with a live Z80 select that reset must mask.
        z80_ram_cs = 1'b1; z80_rd_n = 1'b0;
        repeat (3) tick();
        check_val("rst_dtack", m68k_dtack_n, 1);
        check_val("rst_wait", z80_wait_n, 1);
        check_val("rst_we", ram_we, 0);
        check_val("rst_addr", ram_addr, 0);
        check_val("rst_din", ram_din, 0);
        check_val("rst_mdout", m68k_ram_dout, 0);
        check_val("rst_zdout", z80_ram_dout, 0);
`ifdef SHRAM_CONTENTION_CNT_EN
        check_val("rst_cnt", contention_cnt, 0);
`endif
        z80_ram_cs = 1'b0; z80_rd_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();

        // First tie after reset goes to the M68K; Z80 write follows.
        run_pair(2, 1'b1, 11'h123, 8'h00, 1'b0, 1'b0, 11'h200, 8'h77, "tie1");
        check_val("tie1_z_we_addr", we_addr, 11'h200);
        run_pair(0, 1'b0, 11'h123, 8'h5a, 1'b0, 1'b1, 11'h000, 8'h00, "mwr");
        run_pair(1, 1'b1, 11'h000, 8'h00, 1'b0, 1'b1, 11'h123, 8'h00, "zrd");
        run_pair(0, 1'b0, 11'h010, 8'h11, 1'b0, 1'b1, 11'h000, 8'h00, "mwr2");
        // After an M68K grant, the next tie goes to the Z80.
        run_pair(2, 1'b1, 11'h123, 8'h00, 1'b0, 1'b1, 11'h010, 8'h00, "tie2");
        run_pair(0, 1'b0, 11'h123, 8'hee, 1'b1, 1'b1, 11'h000, 8'h00, "lds_hi");

        // M68K abandons a write during ACCESS while the Z80 starts a read.
        shared_ram_cs = 1'b1; cpu_a = 11'h055; cpu_rw = 1'b0; cpu_lds_n = 1'b0; cpu_dout = 8'hc3;
        tick();
        check_val("abort_we", ram_we, 1);
        check_val("abort_we_addr", ram_addr, 11'h055);
        shared_ram_cs = 1'b0; cpu_rw = 1'b1; cpu_lds_n = 1'b1;
        z80_ram_cs = 1'b1; z80_addr = 11'h055; z80_rd_n = 1'b0;
        #1;
        check_val("abort_wait_assert", z80_wait_n, 0);
        n = 0; dt_low = 1'b0;
        while (!z80_wait_n && n < 40) begin
            @(posedge clk_sys); #1;
            n++;
            if (!m68k_dtack_n) dt_low = 1'b1;
        end
        check_val("abort_wait_edges", n, 4);
        check_val("abort_dtack_never", dt_low, 0);
        check_val("abort_zdata", z80_ram_dout, 8'hc3);
        shadow[11'h055] = 8'hc3;
        last_z = 1'b1;
        z80_ram_cs = 1'b0; z80_rd_n = 1'b1;
        tick();

        // Reset while an M68K read sits in DATA, Z80 waiting.
        shared_ram_cs = 1'b1; cpu_a = 11'h123; cpu_rw = 1'b1;
        z80_ram_cs = 1'b1; z80_addr = 11'h010; z80_rd_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_val("mrst_we", ram_we, 0);
        check_val("mrst_dtack", m68k_dtack_n, 1);
        check_val("mrst_wait", z80_wait_n, 1);
        check_val("mrst_addr", ram_addr, 0);
        check_val("mrst_mdout", m68k_ram_dout, 0);
        shared_ram_cs = 1'b0; z80_ram_cs = 1'b0; z80_rd_n = 1'b1;
        tick();
        reset_n = 1'b1;
        last_z = 1'b1;
        tick();
`ifdef SHRAM_CONTENTION_CNT_EN
        check_val("mrst_cnt", contention_cnt, 0);
`endif
        run_pair(0, 1'b1, 11'h123, 8'h00, 1'b0, 1'b1, 11'h000, 8'h00, "post_rst");

        for (int it = 0; it < 60; it++) begin
            run_pair(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     11'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                     11'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                     $sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
